// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder/subtractor: operation encoding,
// per-stage control bundle and the slice width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    ADD_SAT = 2'b10,
    SUB_SAT = 2'b11
  } add_mode_e;

  // Control that travels with each transaction from slice to slice.
  // carry is the raw chunk carry between slices, and the final carry/borrow
  // after the last slice. Partial sum and skewed operands travel as
  // WIDTH-bit vectors next to this bundle.
  typedef struct packed {
    logic      vld;
    add_mode_e mode;
    logic      carry;
    logic      sat;
  } stage_ctrl_t;

  // Bits handled by one pipeline slice.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One pipeline slice: adds one CHUNK of the operands plus the incoming carry,
// forwards operands and already-produced result bits, and holds on stall.
// The last slice also converts the final carry to a borrow for subtraction
// and applies unsigned saturation.
module adder_slice
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              adv,
  input  stage_ctrl_t       ctrl_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [WIDTH-1:0]  res_i,
  output stage_ctrl_t       ctrl_o,
  output logic [WIDTH-1:0]  a_o,
  output logic [WIDTH-1:0]  b_o,
  output logic [WIDTH-1:0]  res_o
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LO    = IDX * CHUNK;
  localparam bit LAST  = (IDX == STAGES - 1);

  logic             is_sub;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             sat_d;

  logic             vld_q;
  add_mode_e        mode_q;
  logic             carry_q;
  logic             sat_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  // Incoming sat flag is always zero ahead of the last slice.
  logic unused_sat;
  assign unused_sat = ctrl_i.sat;

  function automatic logic sat_hit(input add_mode_e m, input logic flag);
    return flag && ((m == ADD_SAT) || (m == SUB_SAT));
  endfunction

  function automatic logic [WIDTH-1:0] sat_value(input add_mode_e m);
    return (m == ADD_SAT) ? {WIDTH{1'b1}} : '0;
  endfunction

  // Chunk add, result bit merge and last-slice carry/saturation handling.
  always_comb begin
    is_sub  = (ctrl_i.mode == SUB) || (ctrl_i.mode == SUB_SAT);
    b_eff   = is_sub ? ~b_i[LO +: CHUNK] : b_i[LO +: CHUNK];
    csum    = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_eff} + {{CHUNK{1'b0}}, ctrl_i.carry};
    res_raw = res_i;
    res_raw[LO +: CHUNK] = csum[CHUNK-1:0];
    carry_d = csum[CHUNK];
    sat_d   = 1'b0;
    res_d   = res_raw;
    if (LAST) begin
      carry_d = is_sub ? ~csum[CHUNK] : csum[CHUNK];
      sat_d   = sat_hit(ctrl_i.mode, carry_d);
      if (sat_d) res_d = sat_value(ctrl_i.mode);
    end
  end

  // Stage valid bit: cleared by reset, moves only when the pipe advances.
  always_ff @(posedge clk) begin
    if (!rstn)    vld_q <= 1'b0;
    else if (adv) vld_q <= ctrl_i.vld;
  end

  // Stage data: held on stall; only the output slice clears its result on reset.
  always_ff @(posedge clk) begin
    if (!rstn && LAST) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (adv) begin
      mode_q  <= ctrl_i.mode;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      a_q     <= a_i;
      b_q     <= b_i;
      res_q   <= res_d;
    end
  end

  assign ctrl_o = '{vld: vld_q, mode: mode_q, carry: carry_q, sat: sat_q};
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign res_o  = res_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with optional unsigned saturation.
// The carry chain is cut into STAGES slices; the whole pipe advances together
// whenever the output register is empty or being drained.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             sat
);

  if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipe: WIDTH must be >= 2 and a multiple of STAGES");
  end

  stage_ctrl_t      ctrl_s0;
  stage_ctrl_t      ctrl_q [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];
  logic             advance;
  logic             unused_tail;

  // Subtraction enters slice 0 with carry-in 1 (a + ~b + 1).
  assign ctrl_s0 = '{vld: in_valid, mode: add_mode_e'(mode), carry: mode[0], sat: 1'b0};

  assign advance  = !ctrl_q[STAGES-1].vld || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_ctrl_t      ctrl_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res_in;

    if (k == 0) begin : g_first
      assign ctrl_in = ctrl_s0;
      assign a_in    = a;
      assign b_in    = b;
      assign res_in  = '0;
    end else begin : g_next
      assign ctrl_in = ctrl_q[k-1];
      assign a_in    = a_q[k-1];
      assign b_in    = b_q[k-1];
      assign res_in  = res_q[k-1];
    end

    adder_slice #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_slice (
      .clk    (clk),
      .rstn   (rstn),
      .adv    (advance),
      .ctrl_i (ctrl_in),
      .a_i    (a_in),
      .b_i    (b_in),
      .res_i  (res_in),
      .ctrl_o (ctrl_q[k]),
      .a_o    (a_q[k]),
      .b_o    (b_q[k]),
      .res_o  (res_q[k])
    );
  end

  assign out_valid = ctrl_q[STAGES-1].vld;
  assign carry     = ctrl_q[STAGES-1].carry;
  assign sat       = ctrl_q[STAGES-1].sat;
  assign sum       = res_q[STAGES-1];

  // Operands and mode are not needed past the final slice.
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], ctrl_q[STAGES-1].mode};

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 8-bit/2-stage main instance plus
// 32-bit/4-stage and 16-bit/1-stage instances for the parameter sweep.
module tb_adder_pipe;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ADS = 2'b10;
  localparam logic [1:0] M_SBS = 2'b11;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // 8-bit, 2 stages
  logic       in_valid8, in_ready8, out_valid8, out_ready8, carry8, sat8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] mode8;
  // 32-bit, 4 stages
  logic        in_valid32, in_ready32, out_valid32, out_ready32, carry32, sat32;
  logic [31:0] a32, b32, sum32;
  logic [1:0]  mode32;
  // 16-bit, 1 stage
  logic        in_valid16, in_ready16, out_valid16, out_ready16, carry16, sat16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  mode16;

  adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry(carry8), .sat(sat8));

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .mode(mode32), .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .carry(carry32), .sat(sat32));

  adder_pipe #(.WIDTH(16), .STAGES(1)) u_dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .carry(carry16), .sat(sat16));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 8-bit result packed as {carry, sat, sum}; subtraction via a
  // 9-bit difference whose top bit is the borrow.
  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                      input logic [1:0] m);
    logic [8:0] t;
    logic [7:0] r;
    logic       s;
    t = m[0] ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    r = t[7:0];
    s = 1'b0;
    if (m == M_ADS && t[8]) begin r = 8'hFF; s = 1'b1; end
    if (m == M_SBS && t[8]) begin r = 8'h00; s = 1'b1; end
    return {t[8], s, r};
  endfunction

  // One isolated 8-bit transaction: check the 2-edge latency and result.
  task automatic single8(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] m, input logic [7:0] es, input logic ec,
                         input logic ess);
    a8 = x; b8 = y; mode8 = m; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    chk({tag, "_lat1"}, out_valid8, 0);
    tick();
    chk({tag, "_valid"}, out_valid8, 1);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_carry"}, carry8, ec);
    chk({tag, "_sat"}, sat8, ess);
    tick();
  endtask

  logic [7:0]  ta [6];
  logic [7:0]  tb [6];
  logic [1:0]  tm [6];
  logic [9:0]  texp [6];
  logic [9:0]  q [$];
  logic [9:0]  e;
  logic        held, take_in, take_out;
  logic [9:0]  hval;
  int          sent;

  initial begin
    rstn = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; mode8 = 0; out_ready8 = 1;
    in_valid32 = 0; a32 = 0; b32 = 0; mode32 = 0; out_ready32 = 1;
    in_valid16 = 0; a16 = 0; b16 = 0; mode16 = 0; out_ready16 = 1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_in_ready", in_ready8, 1);
    rstn = 1'b1;
    tick();

    // Directed arithmetic cases
    single8("add_carry", 8'hC8, 8'h64, M_ADD, 8'h2C, 1'b1, 1'b0);
    single8("addsat_hit", 8'hC8, 8'h64, M_ADS, 8'hFF, 1'b1, 1'b1);
    single8("addsat_miss", 8'h10, 8'h20, M_ADS, 8'h30, 1'b0, 1'b0);
    single8("sub_borrow", 8'h05, 8'h0A, M_SUB, 8'hFB, 1'b1, 1'b0);
    single8("subsat_hit", 8'h05, 8'h0A, M_SBS, 8'h00, 1'b1, 1'b1);
    single8("sub_noborrow", 8'h0A, 8'h05, M_SUB, 8'h05, 1'b0, 1'b0);
    single8("subsat_miss", 8'h0A, 8'h05, M_SBS, 8'h05, 1'b0, 1'b0);

    // Full throughput with mode changing every cycle
    ta = '{8'hF0, 8'h05, 8'hF0, 8'h30, 8'h40, 8'h10};
    tb = '{8'h20, 8'h0A, 8'h20, 8'h10, 8'h30, 8'h20};
    tm = '{M_ADD, M_SUB, M_ADS, M_SBS, M_ADS, M_SBS};
    texp = '{{1'b1, 1'b0, 8'h10}, {1'b1, 1'b0, 8'hFB}, {1'b1, 1'b1, 8'hFF},
             {1'b0, 1'b0, 8'h20}, {1'b0, 1'b0, 8'h70}, {1'b1, 1'b1, 8'h00}};
    out_ready8 = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        a8 = ta[i]; b8 = tb[i]; mode8 = tm[i]; in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("tput%0d_valid", i - 1), out_valid8, 1);
        chk($sformatf("tput%0d_res", i - 1), {carry8, sat8, sum8}, texp[i-1]);
      end
    end
    tick();
    chk("tput_drained", out_valid8, 0);

    // Streaming with pseudo-random backpressure against the reference model
    sent = 0; held = 1'b0; hval = '0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom); in_valid8 = 1'b1;
    for (int cyc = 0; cyc < 400 && !(sent == 16 && q.size() == 0); cyc++) begin
      out_ready8 = ($urandom_range(0, 2) != 0);
      #1;
      if (held) begin
        chk("stall_valid", out_valid8, 1);
        chk("stall_stable", {carry8, sat8, sum8}, hval);
      end
      if (out_valid8) chk("ready_follows", in_ready8, out_ready8);
      take_out = out_valid8 && out_ready8;
      take_in  = in_valid8 && in_ready8;
      if (take_out) begin
        if (q.size() == 0) begin
          chk("stream_extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_res", {carry8, sat8, sum8}, e);
        end
      end
      held = out_valid8 && !out_ready8;
      hval = {carry8, sat8, sum8};
      if (take_in) q.push_back(ref8(a8, b8, mode8));
      tick();
      if (take_in) begin
        sent++;
        if (sent < 16) begin
          a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom);
        end else begin
          in_valid8 = 1'b0;
        end
      end
    end
    chk("stream_complete", {sent == 16, q.size() == 0}, 2'b11);
    out_ready8 = 1'b1;
    repeat (2) tick();

    // Reset with two transactions in flight, output stalled during reset
    a8 = 8'hC8; b8 = 8'h64; mode8 = M_ADS; in_valid8 = 1'b1;
    tick();
    a8 = 8'h05; b8 = 8'h0A; mode8 = M_SUB;
    tick();
    chk("prerst_valid", out_valid8, 1);
    chk("prerst_sum", sum8, 8'hFF);
    in_valid8 = 1'b0; out_ready8 = 1'b0; rstn = 1'b0;
    tick();
    tick();
    chk("midrst_valid", out_valid8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_carry", carry8, 0);
    chk("midrst_sat", sat8, 0);
    chk("midrst_in_ready", in_ready8, 1);
    rstn = 1'b1; out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("postrst_quiet%0d", i), out_valid8, 0);
    end

    // 32-bit, 4 stages: carry ripples through every slice
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; mode32 = M_ADD; in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("w32_lat%0d", i), out_valid32, 0);
      tick();
    end
    chk("w32_valid", out_valid32, 1);
    chk("w32_sum", sum32, 0);
    chk("w32_carry", carry32, 1);
    chk("w32_sat", sat32, 0);
    tick();

    // 16-bit, 1 stage: single-cycle latency
    a16 = 16'hFFFF; b16 = 16'h0001; mode16 = M_ADD; in_valid16 = 1'b1;
    tick();
    chk("w16_add_valid", out_valid16, 1);
    chk("w16_add_res", {carry16, sat16, sum16}, {1'b1, 1'b0, 16'h0000});
    a16 = 16'h1234; b16 = 16'h0235; mode16 = M_SUB;
    tick();
    in_valid16 = 1'b0;
    chk("w16_sub_res", {carry16, sat16, sum16}, {1'b0, 1'b0, 16'h0FFF});
    tick();
    chk("w16_idle", out_valid16, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
